// File: rtl/mem_copy_pkg.sv
// Shared types for the memory copy/fill engine: FSM state encoding and the
// mode constants.
package mem_copy_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FINISH
   } copy_state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-granular block move / block fill bus master. A copy alternates one READ and one
// WRITE cycle per word, memmove-safe. A fill issues back-to-back WRITE cycles.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned LEN_W     = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [LEN_W-1:0]  words_done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   localparam int unsigned SUM_W = LEN_W + ADDR_W + 1;
   localparam logic [SUM_W-1:0] DEPTH_EXT = SUM_W'(MEM_DEPTH);

   copy_state_t       state;
   logic              mode_q;
   logic              desc_q;
   logic              err_q;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  len_q;
   logic [DATA_W-1:0] fill_q;
   logic [DATA_W-1:0] buf_q;

   logic [SUM_W-1:0]  src_ext;
   logic [SUM_W-1:0]  dst_ext;
   logic [SUM_W-1:0]  src_end;
   logic [SUM_W-1:0]  dst_end;
   logic              range_bad;
   logic              go_desc;

   // Widened sums so a range near the top of the address space cannot wrap into "valid".
   always_comb begin
      src_ext   = SUM_W'(src_addr);
      dst_ext   = SUM_W'(dst_addr);
      src_end   = src_ext + SUM_W'(length);
      dst_end   = dst_ext + SUM_W'(length);
      range_bad = (dst_end > DEPTH_EXT) || ((mode == MODE_COPY) && (src_end > DEPTH_EXT));
      go_desc   = (mode == MODE_COPY) && (src_ext < dst_ext) && (dst_ext < src_end);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mode_q     <= MODE_COPY;
         desc_q     <= 1'b0;
         err_q      <= 1'b0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         len_q      <= '0;
         fill_q     <= '0;
         buf_q      <= '0;
         words_done <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  len_q      <= length;
                  fill_q     <= fill_value;
                  desc_q     <= go_desc;
                  words_done <= '0;
                  err_q      <= 1'b0;
                  if (go_desc) begin
                     src_ptr <= src_addr + ADDR_W'(length) - ADDR_W'(1);
                     dst_ptr <= dst_addr + ADDR_W'(length) - ADDR_W'(1);
                  end else begin
                     src_ptr <= src_addr;
                     dst_ptr <= dst_addr;
                  end
                  if (length == '0) begin
                     state <= FINISH;
                  end else if (range_bad) begin
                     err_q <= 1'b1;
                     state <= FINISH;
                  end else if (mode == MODE_COPY) begin
                     state <= READ;
                  end else begin
                     state <= WRITE;
                  end
               end
            end
            READ: begin
               buf_q <= read_data;
               state <= WRITE;
            end
            WRITE: begin
               if (desc_q) begin
                  src_ptr <= src_ptr - ADDR_W'(1);
                  dst_ptr <= dst_ptr - ADDR_W'(1);
               end else begin
                  src_ptr <= src_ptr + ADDR_W'(1);
                  dst_ptr <= dst_ptr + ADDR_W'(1);
               end
               words_done <= words_done + LEN_W'(1);
               if (words_done == len_q - LEN_W'(1)) begin
                  state <= FINISH;
               end else if (mode_q == MODE_COPY) begin
                  state <= READ;
               end
            end
            FINISH: begin
               err_q <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Moore decode: bus depends only on state and latched registers, never on start.
   always_comb begin
      busy       = (state != IDLE);
      done       = (state == FINISH);
      error      = (state == FINISH) && err_q;
      mem_read   = (state == READ);
      mem_write  = (state == WRITE);
      address    = '0;
      write_data = '0;
      if (state == READ) begin
         address = src_ptr;
      end else if (state == WRITE) begin
         address    = dst_ptr;
         write_data = (mode_q == MODE_FILL) ? fill_q : buf_q;
      end
   end

endmodule
